// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared state and mode constants for the sequencing mux scanner
package mux_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_out_reg.sv
// rtl/mux_out_reg.sv - valid/ready output register with capture enable
module mux_out_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture_en,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             captured
);

  // A new sample only lands when the slot is empty or being drained this edge.
  assign captured = capture_en && (!valid || ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (captured) begin
      q     <= d;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_mux_scanner.sv
// rtl/seq_mux_scanner.sv - registered N:1 mux with direct select and round-robin scan
module seq_mux_scanner
  import mux_pkg::*;
#(
  parameter int NUM_IN = 7,
  parameter int WIDTH  = 1,
  parameter int SEL_W  = 3,
  parameter int DWELL  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        address,
  input  logic                    mode,
  input  logic                    sel_load,
  input  logic                    enable,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    scan_wrap,
  output logic                    addr_err
);

  localparam int CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] DWELL_C  = CNT_W'(DWELL);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_IN - 1);
  localparam logic [SEL_W:0]   NUM_IN_C = (SEL_W + 1)'(NUM_IN);

  logic [1:0]       state;
  logic [CNT_W-1:0] dwell_cnt;
  logic [CNT_W-1:0] dwell_inc;
  logic [WIDTH-1:0] sel_data;
  logic             active;
  logic             captured;
  logic             addr_oor;

  // Out-of-range selections read as zero rather than indexing past the bank.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (cur_sel == SEL_W'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign active    = enable && ((state == ST_DIRECT) || (state == ST_SCAN));
  assign addr_oor  = {1'b0, address} >= NUM_IN_C;
  assign dwell_inc = dwell_cnt + CNT_W'(1);

  mux_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture_en (active),
    .d          (sel_data),
    .ready      (out_ready),
    .q          (out_data),
    .valid      (out_valid),
    .captured   (captured)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cur_sel   <= '0;
      dwell_cnt <= '0;
      scan_wrap <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      scan_wrap <= 1'b0;
      if (!enable) begin
        state <= ST_IDLE;
      end else if (sel_load) begin
        case (mode)
          MODE_SCAN: begin
            state     <= ST_SCAN;
            cur_sel   <= '0;
            dwell_cnt <= '0;
          end
          MODE_DIRECT: begin
            state   <= ST_DIRECT;
            cur_sel <= address;
            if (addr_oor) addr_err <= 1'b1;
          end
        endcase
      end else if ((state == ST_SCAN) && captured) begin
        if (dwell_inc == DWELL_C) begin
          dwell_cnt <= '0;
          if (cur_sel == LAST_SEL) begin
            cur_sel   <= '0;
            scan_wrap <= 1'b1;
          end else begin
            cur_sel <= cur_sel + SEL_W'(1);
          end
        end else begin
          dwell_cnt <= dwell_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_mux_scanner.sv
// tb/tb_seq_mux_scanner.sv - randomized and directed checks against a behavioural model
module tb_seq_mux_scanner;

  localparam int NUM_IN = 7;
  localparam int WIDTH  = 4;
  localparam int SEL_W  = 3;
  localparam int DWELL  = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_IN*WIDTH-1:0] in_data = '0;
  logic [SEL_W-1:0]        address = '0;
  logic                    mode = 1'b0;
  logic                    sel_load = 1'b0;
  logic                    enable = 1'b1;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [SEL_W-1:0]        cur_sel;
  logic                    scan_wrap;
  logic                    addr_err;

  int checks = 0;
  int failures = 0;

  seq_mux_scanner #(.NUM_IN(NUM_IN), .WIDTH(WIDTH), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .address   (address),
    .mode      (mode),
    .sel_load  (sel_load),
    .enable    (enable),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cur_sel   (cur_sel),
    .scan_wrap (scan_wrap),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 direct, 2 scan; selection and dwell as plain integers.
  int m_mode = 0;
  int m_sel = 0;
  int m_cnt = 0;
  int m_data = 0;
  bit m_valid = 0;
  bit m_wrap = 0;
  bit m_err = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_sel = 0; m_cnt = 0; m_data = 0;
      m_valid = 0; m_wrap = 0; m_err = 0;
    end else begin
      bit cap;
      cap = enable && (m_mode != 0) && (!m_valid || out_ready);
      if (cap) begin
        m_data  = (m_sel < NUM_IN) ? int'(in_data[m_sel*WIDTH +: WIDTH]) : 0;
        m_valid = 1;
      end else if (out_ready) begin
        m_valid = 0;
      end
      m_wrap = 0;
      if (!enable) begin
        m_mode = 0;
      end else if (sel_load) begin
        if (mode) begin
          m_mode = 2; m_sel = 0; m_cnt = 0;
        end else begin
          m_mode = 1; m_sel = int'(address);
          if (int'(address) >= NUM_IN) m_err = 1;
        end
      end else if (m_mode == 2 && cap) begin
        m_cnt++;
        if (m_cnt == DWELL) begin
          m_cnt = 0;
          m_wrap = (m_sel == NUM_IN - 1);
          m_sel = (m_sel + 1) % NUM_IN;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("model_out_valid", int'(out_valid), int'(m_valid));
    chk("model_out_data", int'(out_data), m_data);
    chk("model_cur_sel", int'(cur_sel), m_sel);
    chk("model_scan_wrap", int'(scan_wrap), int'(m_wrap));
    chk("model_addr_err", int'(addr_err), int'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ch(input int ch, input int val);
    in_data[ch*WIDTH +: WIDTH] = WIDTH'(val);
  endtask

  int seq[$];
  int wraps;
  int exp_seq[15] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 0};

  initial begin
    tick();
    tick();
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_cur_sel", int'(cur_sel), 0);
    chk("reset_addr_err", int'(addr_err), 0);
    rst_n = 1'b1;
    tick();

    // Direct mode on channel 5
    set_ch(5, 'hA);
    sel_load = 1'b1; address = 3'd5; mode = 1'b0;
    tick();
    sel_load = 1'b0;
    chk("direct_cur_sel", int'(cur_sel), 5);
    tick();
    chk("direct_data", int'(out_data), 'hA);
    chk("direct_valid", int'(out_valid), 1);
    for (int i = 0; i < 6; i++) begin
      set_ch(5, int'($urandom_range(0, 15)));
      tick();
    end

    // Backpressure on channel 2
    set_ch(2, 3);
    sel_load = 1'b1; address = 3'd2;
    tick();
    sel_load = 1'b0;
    tick();
    out_ready = 1'b0;
    set_ch(2, 7);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data", int'(out_data), 3);
      chk("stall_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    tick();
    chk("stall_release_data", int'(out_data), 7);

    // Scan sequence
    for (int i = 0; i < NUM_IN; i++) set_ch(i, i);
    sel_load = 1'b1; mode = 1'b1;
    tick();
    sel_load = 1'b0;
    wraps = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      seq.push_back(int'(out_data));
      if (scan_wrap) wraps++;
    end
    for (int k = 0; k < 15; k++) chk("scan_seq", seq[k], exp_seq[k]);
    chk("scan_wrap_count", wraps, 1);

    // Out-of-range address
    sel_load = 1'b1; mode = 1'b0; address = 3'd7;
    tick();
    sel_load = 1'b0;
    chk("oor_addr_err", int'(addr_err), 1);
    tick();
    chk("oor_data", int'(out_data), 0);
    sel_load = 1'b1; address = 3'd1;
    tick();
    sel_load = 1'b0;
    tick();
    chk("oor_recover_data", int'(out_data), 1);
    chk("oor_err_sticky", int'(addr_err), 1);

    // Enable beats sel_load; held sample waits for handshake
    out_ready = 1'b0;
    tick();
    enable = 1'b0; sel_load = 1'b1; address = 3'd4;
    tick();
    chk("en_prio_cur_sel", int'(cur_sel), 1);
    chk("en_prio_valid", int'(out_valid), 1);
    enable = 1'b1; sel_load = 1'b0;
    tick();
    chk("idle_hold_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    chk("idle_drain_valid", int'(out_valid), 0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 7);
      enable    = ($urandom_range(0, 19) != 0);
      sel_load  = ($urandom_range(0, 19) == 0);
      mode      = $urandom_range(0, 1) == 1;
      address   = SEL_W'($urandom_range(0, 7));
      tick();
    end

    // Asynchronous reset mid-scan
    enable = 1'b1; out_ready = 1'b1; sel_load = 1'b1; mode = 1'b1;
    tick();
    sel_load = 1'b0;
    tick();
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_out_data", int'(out_data), 0);
    chk("async_cur_sel", int'(cur_sel), 0);
    chk("async_scan_wrap", int'(scan_wrap), 0);
    chk("async_addr_err", int'(addr_err), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_reset_idle_valid", int'(out_valid), 0);
      chk("post_reset_idle_sel", int'(cur_sel), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
